instruct_fetch_queue: RTL and testbench
=======================================

# instruct_fetch_queue

Parametrised instruction-fetch stage for the pipelined ARM CPU: holds the PC, reads an external instruction memory each cycle, and buffers fetched {PC, instruction} pairs in a DEPTH-entry queue feeding decode through a valid/ready handshake. Decode can stall without losing fetched words. A redirect (taken branch or exception) flushes the queue and reloads the PC in one cycle. It sits between the instruction memory and the IF/ID boundary, replacing the fixed one-deep fetch register.

## Interface
- ADDR_W, 64, PC / instruction-address width
- INSTR_W, 32, instruction width
- DEPTH, 4, fetch-queue entries (≥2, need not be a power of 2)
- PC_INC, 4, sequential PC increment
- RESET_PC, 0, PC loaded at reset
- NOP, 0, value driven on out_instr when out_valid=0

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- imem_addr  out  ADDR_W  current fetch address (= PC register)
- imem_rdata  in  INSTR_W  instruction at imem_addr, valid combinationally in the same cycle
- redirect  in  1  flush queue and load PC from redirect_addr
- redirect_addr  in  ADDR_W  new fetch target
- out_valid  out  1  queue head holds an instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  INSTR_W  head instruction (NOP when out_valid=0)
- out_pc  out  ADDR_W  address of head instruction (0 when out_valid=0)
- occupancy  out  clog2(DEPTH+1)  entries held

## Operation
- State: PC register, DEPTH-entry storage of {pc, instr}, read pointer, write pointer, count.
- pop = out_valid & out_ready; push = !redirect & (count<DEPTH | pop).
- Push: entry[wr] ← {PC, imem_rdata}; wr advances; PC ← PC + PC_INC (mod 2^ADDR_W, wraps silently).
- No push (full, no pop): PC holds; imem_addr stays stable so the same word is re-read next cycle.
- Pop: rd advances; count decrements unless pushing in the same cycle (push & pop ⇒ count unchanged).
- Pointers wrap DEPTH-1 → 0.
- Redirect has absolute priority: on the edge, count←0, rd←wr←0, PC←redirect_addr. Any same-cycle pop is still accepted by decode (consumed, not replayed); the same-cycle imem word is discarded.
- Full with simultaneous pop: push allowed, count stays DEPTH.
- Empty with out_ready=1: no pop, nothing happens to count.
- Outputs out_valid/out_instr/out_pc/occupancy are derived from registered state only (no combinational path from imem_rdata, out_ready or redirect to them).

## Timing
- Reset (asynchronous, any time, including mid-stream): PC=RESET_PC, count=0, pointers=0, out_valid=0, out_instr=NOP, out_pc=0, occupancy=0, imem_addr=RESET_PC. Storage contents are don't-care.
- First cycle after reset deasserts: imem_addr=RESET_PC; push on that edge; out_valid=1 with out_pc=RESET_PC in the next cycle (fetch-to-decode latency 1 edge).
- Steady state, out_ready=1: one instruction per cycle; occupancy settles at 1.
- Redirect asserted in cycle N: cycle N+1 out_valid=0, imem_addr=redirect_addr; cycle N+2 out_valid=1, out_pc=redirect_addr (2-edge redirect penalty).
- Redirect held multiple cycles: queue stays empty, PC reloaded each edge.
- Stalled (out_ready=0): out_instr/out_pc hold stable; queue fills to DEPTH after DEPTH edges, then PC freezes.

## Test plan
- Reset release, out_ready=1, RESET_PC=0, imem returns addr-derived words -> out_pc sequence 0,4,8,… one per cycle from 1 cycle after release; occupancy=1 steady.
- out_ready=0 for 6 cycles from reset -> occupancy 1,2,3,4,4,4; imem_addr frozen at 0x10; release ready -> out_pc 0,4,8,C,10,14 with no gap or duplicate.
- Full queue, out_ready=1 single cycle -> push and pop same edge, occupancy stays 4, next out_pc advances by 4.
- Redirect to 0x400 with 3 entries queued and out_ready=1 -> head popped that cycle, next cycle out_valid=0/out_instr=NOP, following cycle out_pc=0x400.
- PC=2^ADDR_W−4 sequential fetch -> next out_pc=0 (wrap), no error.
- Assert reset (0) mid-stream with queue at 3 -> immediately out_valid=0, occupancy=0, imem_addr=RESET_PC without waiting for a clock edge.

Source files
------------

// File: rtl/instruct_fetch_queue_if.sv
// Fetch-queue bus: instruction memory port, redirect request and decode-side handshake.
interface instruct_fetch_queue_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) ();
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [OCC_W-1:0]   occupancy;

    // Fetch stage side
    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect,
        input  redirect_addr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output occupancy
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect,
        output redirect_addr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  occupancy
    );
endinterface

// File: rtl/instruct_fetch_queue.sv
// Instruction fetch stage: PC register, combinational imem read, and a DEPTH-entry
// {pc, instr} queue toward decode. A redirect flushes the queue and reloads the PC.
module instruct_fetch_queue #(
    parameter int                  ADDR_W   = 64,
    parameter int                  INSTR_W  = 32,
    parameter int                  DEPTH    = 4,
    parameter int                  PC_INC   = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter logic [INSTR_W-1:0]  NOP      = '0
) (
    input logic                    clk,
    input logic                    reset,
    instruct_fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pc;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   count;
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic has_data;
    logic not_full;
    logic pop;
    logic push;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake decisions; a redirect suppresses the push so the in-flight word is dropped
    always_comb begin
        has_data = (count != '0);
        not_full = (count < OCC_W'(DEPTH));
        pop      = has_data & bus.out_ready;
        push     = !bus.redirect & (not_full | pop);
    end

    // PC, pointers and occupancy; redirect wins over everything except reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            pc     <= bus.redirect_addr;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
                pc     <= pc + ADDR_W'(PC_INC);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Queue storage; contents after reset are irrelevant because count gates the outputs
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.out_valid = has_data;
    assign bus.out_instr = has_data ? instr_mem[rd_ptr] : NOP;
    assign bus.out_pc    = has_data ? pc_mem[rd_ptr] : '0;
    assign bus.occupancy = count;
endmodule

// File: tb/tb_instruct_fetch_queue.sv
// Scoreboard bench for instruct_fetch_queue: stimulus drives a queue-level model and
// pushes expected {pc, instr} entries; a negedge monitor compares and pops them.
module tb_instruct_fetch_queue;
    localparam int          AW   = 64;
    localparam int          IW   = 32;
    localparam int          D    = 4;
    localparam int          PI   = 4;
    localparam logic [63:0] RPC  = 64'h0;
    localparam logic [31:0] NOPV = 32'hE1A0_0000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instruct_fetch_queue_if #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D)) bus ();

    instruct_fetch_queue #(
        .ADDR_W(AW), .INSTR_W(IW), .DEPTH(D), .PC_INC(PI), .RESET_PC(RPC), .NOP(NOPV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A5A_0000;
    endfunction

    assign bus.imem_rdata = word_at(bus.imem_addr);

    logic [63:0] exp_pc [$];
    logic [31:0] exp_ins [$];
    int          exp_cur = 0;
    logic [63:0] exp_addr = RPC;
    logic [63:0] mpc = RPC;
    bit          flush_pending = 0;
    bit          model_live = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Model of one cycle: decide pop/push from queue length, append what will be fetched
    task automatic step_body(input bit rdy, input bit redir, input logic [63:0] raddr);
        bit pop;
        bit push;
        if (flush_pending) begin
            exp_pc.delete();
            exp_ins.delete();
            flush_pending = 0;
        end
        bus.out_ready     = rdy;
        bus.redirect      = redir;
        bus.redirect_addr = raddr;
        exp_cur  = exp_pc.size();
        exp_addr = mpc;
        pop  = (exp_cur > 0) && rdy;
        push = !redir && ((exp_cur < D) || pop);
        if (push) begin
            exp_pc.push_back(mpc);
            exp_ins.push_back(word_at(mpc));
            mpc = mpc + 64'(PI);
        end
        if (redir) begin
            mpc = raddr;
            flush_pending = 1;
        end
        model_live = 1;
    endtask

    task automatic step(input bit rdy, input bit redir, input logic [63:0] raddr);
        @(posedge clk);
        #1;
        step_body(rdy, redir, raddr);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_occ"},   64'(bus.occupancy), 64'd0);
        chk({tag, "_addr"},  bus.imem_addr, RPC);
        chk({tag, "_instr"}, 64'(bus.out_instr), 64'(NOPV));
        chk({tag, "_pc"},    bus.out_pc, 64'd0);
    endtask

    task automatic release_reset(input bit rdy);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_pc.delete();
        exp_ins.delete();
        flush_pending = 0;
        mpc = RPC;
        step_body(rdy, 1'b0, 64'd0);
    endtask

    // Monitor: compare status every cycle, compare and retire the head when decode takes it
    initial begin
        forever begin
            @(negedge clk);
            if (model_live && reset) begin
                chk("occupancy", 64'(bus.occupancy), 64'(exp_cur));
                chk("out_valid", 64'(bus.out_valid), 64'(exp_cur > 0));
                chk("imem_addr", bus.imem_addr, exp_addr);
                if (exp_cur > 0) begin
                    chk("out_pc", bus.out_pc, exp_pc[0]);
                    chk("out_instr", 64'(bus.out_instr), 64'(exp_ins[0]));
                    if (bus.out_ready) begin
                        void'(exp_pc.pop_front());
                        void'(exp_ins.pop_front());
                    end
                end else begin
                    chk("idle_instr", 64'(bus.out_instr), 64'(NOPV));
                    chk("idle_pc", bus.out_pc, 64'd0);
                end
            end
        end
    end

    initial begin
        bus.out_ready     = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        #3;
        check_reset_outputs("por");

        // Streaming from reset
        release_reset(1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 64'd0);

        // Build three entries, then assert reset mid-cycle
        step(1'b1, 1'b1, 64'h100);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'd0);
        #2;
        reset = 1'b0;
        model_live = 0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        @(posedge clk);

        // Stall six cycles from reset, then drain
        release_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 64'd0);

        // Full queue with a single-cycle pop
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 64'd0);
        step(1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 64'd0);

        // Redirect to 0x400 with three entries queued
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        step(1'b1, 1'b1, 64'h400);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 64'd0);

        // Held redirect, then PC wrap at the top of the address space
        step(1'b1, 1'b1, 64'h800);
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'd0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bit          rdy;
            bit          redir;
            logic [63:0] ra;
            rdy   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                ra = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
            else
                ra = {$urandom, $urandom} & ~64'h3;
            step(rdy, redir, ra);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'd0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
